// File: rtl/iterative_shifter_pkg.sv
// Shared ALU definitions: shift-type encoding (same as the combinational
// shift path) and the iterative shifter's FSM state encoding.
package iterative_shifter_pkg;

  typedef logic [1:0] shift_type_t;

  localparam shift_type_t SHIFT_SRL  = 2'b00;
  localparam shift_type_t SHIFT_SLL  = 2'b01;
  localparam shift_type_t SHIFT_SRA  = 2'b10;
  localparam shift_type_t SHIFT_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// One shift step: moves the operand by s bits (0..STEP) in the requested
// direction. SRA fills from the sign bit captured at acceptance, so the
// fill stays correct across any number of steps.
module shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] operand_i,
  input  logic [SW-1:0]    s_i,
  input  shift_type_t      type_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] result_o
);

  logic signed [WIDTH:0] ext;
  logic signed [WIDTH:0] ext_sra;

  // Select the shifted operand for the captured shift type.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    ext      = {sign_i, operand_i};
    ext_sra  = ext >>> s_i;
    result_o = operand_i;
    case (type_i)
      SHIFT_SRL: result_o = operand_i >> s_i;
      SHIFT_SLL: result_o = operand_i << s_i;
      SHIFT_SRA: result_o = ext_sra[WIDTH-1:0];
      default:   result_o = operand_i;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle EX-stage shifter: accepts one SRL/SLL/SRA request in IDLE,
// shifts at most STEP bits per cycle, then holds the result in DONE until
// the consumer takes it. flush aborts; rst has priority over flush.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  shift_type_t      op_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r
);

  localparam int SW = $clog2(STEP + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   rem_q, rem_d;
  shift_type_t      type_q, type_d;
  logic             sign_q, sign_d;

  logic [SW-1:0]    step_s;
  logic [WIDTH-1:0] step_result;

  // Bits to move this cycle: min(STEP, remaining).
  always_comb begin
    step_s = SW'(STEP);
    if (rem_q < SHW'(STEP)) step_s = rem_q[SW-1:0];
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .SW    (SW)
  ) u_shift_step (
    .operand_i (work_q),
    .s_i       (step_s),
    .type_i    (type_q),
    .sign_i    (sign_q),
    .result_o  (step_result)
  );

  // Next-state logic: flush overrides everything, then per-state behaviour.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    type_d  = type_q;
    sign_d  = sign_q;

    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_d = a;
            type_d = op_type;
            sign_d = a[WIDTH-1];
            rem_d  = shamt;
            if (shamt == '0 || op_type == SHIFT_PASS) begin
              rem_d   = '0;
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          work_d = step_result;
          rem_d  = rem_q - SHW'(step_s);
          if (rem_q == SHW'(step_s)) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with synchronous reset taking priority over flush.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      type_q  <= SHIFT_SRL;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r         = work_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: a STEP=1 and a STEP=4 instance share the
// same stimulus; each request's expected result and per-instance latency
// is queued at issue and compared when both instances report out_valid.
module tb_iterative_shifter;
  import iterative_shifter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] a;
  logic [4:0]  shamt;
  shift_type_t op_type;

  logic        in_ready1, out_valid1, in_ready4, out_valid4;
  logic [31:0] r1, r4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  typ;
    logic [31:0] exp_r;
    int          hold;
    bit          poke;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    int          lat1;
    int          lat4;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(32), .SHW(5), .STEP(1)) dut1 (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready1),
    .a (a), .shamt (shamt), .op_type (op_type),
    .out_valid (out_valid1), .out_ready (out_ready), .r (r1)
  );

  iterative_shifter #(.WIDTH(32), .SHW(5), .STEP(4)) dut4 (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready4),
    .a (a), .shamt (shamt), .op_type (op_type),
    .out_valid (out_valid4), .out_ready (out_ready), .r (r4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [4:0] sh, input logic [1:0] typ, input int step);
    if (sh == 5'd0 || typ == SHIFT_PASS) return 0;
    return (int'(sh) + step - 1) / step;
  endfunction

  task automatic run_op(input vec_t v);
    exp_t e, got;
    int done1, done4, busy_bad;
    e.r    = v.exp_r;
    e.lat1 = lat_of(v.shamt, v.typ, 1);
    e.lat4 = lat_of(v.shamt, v.typ, 4);
    sb.push_back(e);

    @(negedge clk);
    a = v.a; shamt = v.shamt; op_type = v.typ; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; shamt = 5'($urandom); op_type = 2'($urandom);

    done1 = -1; done4 = -1; busy_bad = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (done1 < 0 && out_valid1) done1 = cyc;
      if (done4 < 0 && out_valid4) done4 = cyc;
      if (done1 < 0 && in_ready1) busy_bad++;
      if (done4 < 0 && in_ready4) busy_bad++;
      if (done1 >= 0 && done4 >= 0) break;
      in_valid = v.poke && cyc >= 2 && cyc < 5;
      if (in_valid) a = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      check({v.name, "_hold_valid"}, 32'(out_valid1), 32'd1);
      check({v.name, "_hold_r"}, r1, v.exp_r);
    end

    got = sb.pop_front();
    check({v.name, "_busy_in_ready"}, 32'(busy_bad), 32'd0);
    check({v.name, "_lat_step1"}, 32'(done1), 32'(got.lat1));
    check({v.name, "_lat_step4"}, 32'(done4), 32'(got.lat4));
    check({v.name, "_r_step1"}, r1, got.r);
    check({v.name, "_r_step4"}, r4, got.r);

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({v.name, "_idle_ready1"}, 32'(in_ready1), 32'd1);
    check({v.name, "_idle_ready4"}, 32'(in_ready4), 32'd1);
    check({v.name, "_idle_valid"}, 32'({out_valid1, out_valid4}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h8000_0000, 5'd4,  SHIFT_SRA,  32'hF800_0000, 0, 1'b0, "sra_sign4"};
    vecs[1]  = '{32'h0000_0001, 5'd31, SHIFT_SLL,  32'h8000_0000, 0, 1'b1, "sll_31_poke"};
    vecs[2]  = '{32'hF000_0000, 5'd0,  SHIFT_SRL,  32'hF000_0000, 0, 1'b0, "srl_zero"};
    vecs[3]  = '{32'h1234_5678, 5'd9,  SHIFT_PASS, 32'h1234_5678, 0, 1'b0, "pass"};
    vecs[4]  = '{32'h0000_00F0, 5'd4,  SHIFT_SRL,  32'h0000_000F, 3, 1'b0, "srl_backpress"};
    vecs[5]  = '{32'hC000_0000, 5'd7,  SHIFT_SRA,  32'hFF80_0000, 0, 1'b0, "sra_7"};
    vecs[6]  = '{32'h7FFF_FFFF, 5'd31, SHIFT_SRA,  32'h0000_0000, 0, 1'b0, "sra_pos31"};
    vecs[7]  = '{32'hDEAD_BEEF, 5'd16, SHIFT_SLL,  32'hBEEF_0000, 0, 1'b0, "sll_16"};
    vecs[8]  = '{32'h8000_0001, 5'd31, SHIFT_SRL,  32'h0000_0001, 0, 1'b0, "srl_31"};
    vecs[9]  = '{32'h8000_F000, 5'd13, SHIFT_SRA,  32'hFFFC_0007, 0, 1'b0, "sra_13"};
    vecs[10] = '{32'h0000_00FF, 5'd5,  SHIFT_SLL,  32'h0000_1FE0, 0, 1'b0, "sll_5"};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; shamt = '0; op_type = SHIFT_SRL;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'({in_ready1, in_ready4}), 32'd3);
    check("reset_out_valid", 32'({out_valid1, out_valid4}), 32'd0);
    check("reset_r1", r1, 32'd0);
    check("reset_r4", r4, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Flush on the 2nd SHIFT cycle of SLL by 10.
    @(negedge clk);
    a = 32'h0000_0001; shamt = 5'd10; op_type = SHIFT_SLL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("flush_pre_busy", 32'({in_ready1, in_ready4}), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 32'({in_ready1, in_ready4}), 32'd3);
    check("flush_no_valid", 32'({out_valid1, out_valid4}), 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #1;
        if (out_valid1 || out_valid4) seen++;
      end
      check("flush_no_late_result", 32'(seen), 32'd0);
    end

    // Request presented together with flush is not accepted.
    @(negedge clk);
    a = 32'h5555_AAAA; shamt = 5'd3; op_type = SHIFT_PASS; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_req_ignored_valid", 32'({out_valid1, out_valid4}), 32'd0);
    check("flush_req_ignored_ready", 32'({in_ready1, in_ready4}), 32'd3);

    // rst together with flush while in DONE.
    @(negedge clk);
    a = 32'hA5A5_A5A5; shamt = 5'd2; op_type = SHIFT_PASS; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_done", 32'({out_valid1, out_valid4}), 32'd3);
    check("pre_rst_r", r1, 32'hA5A5_A5A5);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    check("rst_done_in_ready", 32'({in_ready1, in_ready4}), 32'd3);
    check("rst_done_out_valid", 32'({out_valid1, out_valid4}), 32'd0);
    check("rst_done_r1", r1, 32'd0);
    check("rst_done_r4", r4, 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
